tt_um_mizidd_alu_sequencer: RTL and testbench
=============================================

# tt_um_mizidd_alu_sequencer

Program sequencer for the accumulator ALU. It captures a short program of opcode/operand words from the switches, then replays the words one per clock on its outputs. The outputs wire straight to the ALU's opcode and operand inputs, so users can run multi-step ALU sequences without hand-toggling switches every cycle. The block sits on the driving end of the ALU's opcode/operand interface.

## Interface
Parameters:
- DEPTH, 8, number of program words; a power of two.
- AW, 3, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  design enable; ignored.
- ui_in  input  8  ui_in[6:0] = operand to store; ui_in[7] = loop mode, sampled at run start.
- uio_in  input  8  uio_in[2:0] = opcode to store; uio_in[3] = wr strobe; uio_in[4] = run/stop strobe; uio_in[7:5] unused.
- uo_out  output  8  uo_out[6:0] = replayed operand; uo_out[7] = valid, high while a program word is presented.
- uio_out  output  8  uio_out[7:5] = replayed opcode; uio_out[4:0] = 0.
- uio_oe  output  8  constant 8'b1110_0000.

## Operation
- Memory: DEPTH words, 10 bits each, {opcode[2:0], operand[6:0]}. Contents are not reset.
- Registers:
  - wptr/count, range 0..DEPTH, reset 0.
  - rptr, AW bits.
  - loop flag.
  - Previous-value flops for wr and run, reset 0.
  - Output registers: opcode, operand and valid, all reset 0.
- Edge detection: wr_rise = wr & ~wr_prev, and likewise run_rise. Prev flops update every cycle. Strobes are synchronous level inputs; a held strobe produces a single event.
- State IDLE:
  - wr_rise alone with count < DEPTH: write {uio_in[2:0], ui_in[6:0]} at address count, then count += 1.
  - wr_rise alone with count == DEPTH (full): ignored; memory and count unchanged.
  - wr_rise and run_rise in the same cycle: clear, count := 0. No run starts.
  - run_rise alone with count == 0 (empty): ignored.
  - run_rise alone with count > 0: go to RUN, latch loop := ui_in[7], load output regs with mem[0], valid := 1, rptr := 1.
  - Outputs in IDLE: opcode 000 (NOP), operand 0, valid 0.
- State RUN, on each cycle:
  - If rptr < count: present mem[rptr], then rptr += 1.
  - If rptr == count (all words issued) and loop = 1: present mem[0], rptr := 1.
  - If rptr == count and loop = 0: go to IDLE with NOP/0/valid 0.
  - rptr wrap-around with count == DEPTH: pointer comparison uses AW+1 bits, so all DEPTH words are issued.
  - run_rise: abort. Go to IDLE immediately, outputs NOP/0/valid 0; run_rise takes priority over sequencing.
  - wr_rise: ignored; memory is never written in RUN.
  - Simultaneous wr_rise + run_rise: treated as abort only; no clear.
- Reset, asynchronous: state IDLE, count 0, all outputs 0, prev flops 0. Applies mid-run as well; the program is then lost (count 0).

## Timing
- Write: the word is stored at the clock edge where wr is first sampled high; count is visible one edge later.
- Run start: run first sampled high at edge N. Word 0 is on the outputs after edge N, and word k after edge N+k.
- Non-loop end: the last word is visible after edge N+count-1. Outputs return to NOP with valid 0 after edge N+count.
- Loop: word 0 follows word count-1 on consecutive cycles with no gap; valid stays high.
- Abort: run first sampled high at edge M during RUN. Outputs are NOP with valid 0 after edge M.
- All outputs are registered; there is no combinational path from inputs to outputs.
- uio_oe is constant, including during reset.

## Test plan
- Reset: drive rst_n low asynchronously mid-cycle -> uo_out = 0x00, uio_out = 0x00, uio_oe = 0xE0 immediately. Then pulse run -> outputs stay 0 (empty program).
- Write and run: write (001, 0x05), (010, 0x03), (010, 0x7F); run with ui_in[7] = 0.
  - Required: uo_out = 0x85, 0x83, 0xFF and uio_out[7:5] = 001, 010, 010 on three consecutive cycles.
  - Then uo_out = 0x00.
  - With the ALU attached, the accumulator reads 0x05, 0x08, 0x07 with carry set.
- Full: write 9 words, operands 1..9 -> a run presents operands 1..8 only. A 10th write is still ignored.
- Loop and abort: write 2 words (operands 0x11, 0x22) and run with loop = 1.
  - Required: the sequence 0x11, 0x22, 0x11, 0x22, … with valid continuously high.
  - A run pulse during the run gives uo_out = 0x00 on the next cycle.
- Clear: in IDLE, raise wr and run in the same cycle -> count = 0, and a subsequent run pulse produces no valid output. Holding wr high for 5 cycles stores exactly one word.
- Mid-run reset: assert rst_n low during a RUN -> outputs are 0 immediately, state is IDLE, and count is 0 after release.

Source files
------------

// File: rtl/tt_um_mizidd_alu_sequencer.sv
// Program sequencer for the accumulator ALU: records opcode/operand words
// from the switches and replays them one per clock on the ALU-facing outputs.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   ena         design enable (unused)
//   ui_in       [6:0] operand to store, [7] loop mode (sampled at run start)
//   uio_in      [2:0] opcode to store, [3] wr strobe, [4] run/stop strobe
//   uo_out      [6:0] replayed operand, [7] valid
//   uio_out     [7:5] replayed opcode, [4:0] zero
//   uio_oe      constant 8'hE0
module tt_um_mizidd_alu_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t      state;
    logic [9:0]  mem [DEPTH];
    // count and rptr carry one extra bit so a full program (count == DEPTH)
    // is distinguishable from an empty one and every word gets issued.
    logic [AW:0] count;
    logic [AW:0] rptr;
    logic        loop;
    logic        wr_prev;
    logic        run_prev;
    logic [2:0]  opcode;
    logic [6:0]  operand;
    logic        valid;

    logic        wr;
    logic        run;
    logic        wr_rise;
    logic        run_rise;
    logic        mem_we;
    logic        unused;

    assign wr       = uio_in[3];
    assign run      = uio_in[4];
    assign wr_rise  = wr & ~wr_prev;
    assign run_rise = run & ~run_prev;
    assign mem_we   = (state == IDLE) && wr_rise && !run_rise && (count != FULL);
    assign unused   = &{1'b0, ena, uio_in[7:5]};

    // Program memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[count[AW-1:0]] <= {uio_in[2:0], ui_in[6:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            rptr     <= '0;
            loop     <= 1'b0;
            wr_prev  <= 1'b0;
            run_prev <= 1'b0;
            opcode   <= '0;
            operand  <= '0;
            valid    <= 1'b0;
        end else begin
            wr_prev  <= wr;
            run_prev <= run;
            unique case (state)
                IDLE: begin
                    opcode  <= '0;
                    operand <= '0;
                    valid   <= 1'b0;
                    if (wr_rise && run_rise) begin
                        count <= '0;
                    end else if (wr_rise) begin
                        if (count != FULL)
                            count <= count + 1'b1;
                    end else if (run_rise && count != '0) begin
                        state             <= RUN;
                        loop              <= ui_in[7];
                        {opcode, operand} <= mem[0];
                        valid             <= 1'b1;
                        rptr              <= (AW+1)'(1);
                    end
                end
                RUN: begin
                    // Abort wins over sequencing; write strobes are ignored.
                    if (run_rise) begin
                        state   <= IDLE;
                        opcode  <= '0;
                        operand <= '0;
                        valid   <= 1'b0;
                    end else if (rptr < count) begin
                        {opcode, operand} <= mem[rptr[AW-1:0]];
                        valid             <= 1'b1;
                        rptr              <= rptr + 1'b1;
                    end else if (loop) begin
                        {opcode, operand} <= mem[0];
                        valid             <= 1'b1;
                        rptr              <= (AW+1)'(1);
                    end else begin
                        state   <= IDLE;
                        opcode  <= '0;
                        operand <= '0;
                        valid   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign uo_out  = {valid, operand};
    assign uio_out = {opcode, 5'b0};
    assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_tt_um_mizidd_alu_sequencer.sv
// Directed self-checking bench for tt_um_mizidd_alu_sequencer.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_tt_um_mizidd_alu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int vecs;
    int errs;

    tt_um_mizidd_alu_sequencer #(.DEPTH(8), .AW(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_word(input logic [2:0] op, input logic [6:0] opnd);
        @(negedge clk);
        ui_in  = {1'b0, opnd};
        uio_in = {4'b0000, 1'b1, op};
        @(negedge clk);
        uio_in = 8'h00;
    endtask

    task automatic pulse_run(input logic lp);
        @(negedge clk);
        ui_in[7]  = lp;
        uio_in[4] = 1'b1;
        @(negedge clk);
        uio_in[4] = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        uio_in = 8'h18;
        @(negedge clk);
        uio_in = 8'h00;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        vecs++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hE0) begin
            errs++;
            $display("FAIL reset_async: uo=%h uio=%h oe=%h want 00 00 e0",
                     uo_out, uio_out, uio_oe);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_run(1'b0);
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
                errs++;
                $display("FAIL reset_empty_run[%0d]: uo=%h uio=%h want 00 00",
                         i, uo_out, uio_out);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_write_run();
        logic [7:0] exp_uo  [4];
        logic [7:0] exp_uio [4];
        exp_uo  = '{8'h85, 8'h83, 8'hFF, 8'h00};
        exp_uio = '{8'h20, 8'h40, 8'h40, 8'h00};
        write_word(3'b001, 7'h05);
        write_word(3'b010, 7'h03);
        write_word(3'b010, 7'h7F);
        pulse_run(1'b0);
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (uo_out !== exp_uo[i] || uio_out !== exp_uio[i]) begin
                errs++;
                $display("FAIL write_run[%0d]: uo=%h uio=%h want %h %h",
                         i, uo_out, uio_out, exp_uo[i], exp_uio[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full();
        do_clear();
        for (int i = 1; i <= 10; i++)
            write_word(3'b011, 7'(i));
        pulse_run(1'b0);
        for (int i = 1; i <= 9; i++) begin
            logic [7:0] eu;
            logic [7:0] eo;
            eu = (i <= 8) ? {1'b1, 7'(i)} : 8'h00;
            eo = (i <= 8) ? 8'h60 : 8'h00;
            vecs++;
            if (uo_out !== eu || uio_out !== eo) begin
                errs++;
                $display("FAIL full[%0d]: uo=%h uio=%h want %h %h",
                         i, uo_out, uio_out, eu, eo);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_loop_abort();
        logic [7:0] seq [5];
        seq = '{8'h91, 8'hA2, 8'h91, 8'hA2, 8'h91};
        do_clear();
        write_word(3'b000, 7'h11);
        write_word(3'b000, 7'h22);
        pulse_run(1'b1);
        for (int i = 0; i < 5; i++) begin
            vecs++;
            if (uo_out !== seq[i]) begin
                errs++;
                $display("FAIL loop[%0d]: uo=%h want %h", i, uo_out, seq[i]);
            end
            if (i < 4) @(negedge clk);
        end
        uio_in[4] = 1'b1;
        @(negedge clk);
        uio_in[4] = 1'b0;
        vecs++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            errs++;
            $display("FAIL abort: uo=%h uio=%h want 00 00", uo_out, uio_out);
        end
        @(negedge clk);
        vecs++;
        if (uo_out !== 8'h00) begin
            errs++;
            $display("FAIL abort_stays_idle: uo=%h want 00", uo_out);
        end
    endtask

    task automatic test_clear_hold();
        write_word(3'b111, 7'h55);
        do_clear();
        pulse_run(1'b0);
        for (int i = 0; i < 2; i++) begin
            vecs++;
            if (uo_out !== 8'h00) begin
                errs++;
                $display("FAIL clear_run[%0d]: uo=%h want 00", i, uo_out);
            end
            @(negedge clk);
        end
        ui_in  = 8'h33;
        uio_in = 8'h0D;
        repeat (5) @(negedge clk);
        uio_in = 8'h00;
        write_word(3'b110, 7'h44);
        pulse_run(1'b0);
        vecs++;
        if (uo_out !== 8'hB3 || uio_out !== 8'hA0) begin
            errs++;
            $display("FAIL hold_w0: uo=%h uio=%h want b3 a0", uo_out, uio_out);
        end
        @(negedge clk);
        vecs++;
        if (uo_out !== 8'hC4 || uio_out !== 8'hC0) begin
            errs++;
            $display("FAIL hold_w1: uo=%h uio=%h want c4 c0", uo_out, uio_out);
        end
        @(negedge clk);
        vecs++;
        if (uo_out !== 8'h00) begin
            errs++;
            $display("FAIL hold_end: uo=%h want 00", uo_out);
        end
    endtask

    task automatic test_midrun_reset();
        do_clear();
        write_word(3'b100, 7'h0A);
        write_word(3'b101, 7'h0B);
        pulse_run(1'b1);
        vecs++;
        if (uo_out !== 8'h8A || uio_out !== 8'h80) begin
            errs++;
            $display("FAIL midrun_pre: uo=%h uio=%h want 8a 80", uo_out, uio_out);
        end
        #3 rst_n = 1'b0;
        #1;
        vecs++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hE0) begin
            errs++;
            $display("FAIL midrun_reset: uo=%h uio=%h oe=%h want 00 00 e0",
                     uo_out, uio_out, uio_oe);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if (uo_out !== 8'h00) begin
            errs++;
            $display("FAIL midrun_idle: uo=%h want 00", uo_out);
        end
        pulse_run(1'b0);
        for (int i = 0; i < 2; i++) begin
            vecs++;
            if (uo_out !== 8'h00) begin
                errs++;
                $display("FAIL midrun_lost[%0d]: uo=%h want 00", i, uo_out);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_write_run();
        test_full();
        test_loop_abort();
        test_clear_hold();
        test_midrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
